stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_pkg.sv | 29 ++
 rtl/stage_cfg_lut.sv | 28 ++
 rtl/stage_sequencer.sv | 128 ++++++++++++
 tb/tb_stage_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/stage_pkg.sv
// Shared types and default constants for the three-stage burn sequencer.
package stage_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        BURN  = 3'd2,
        SEP   = 3'd3,
        DONE  = 3'd4,
        ABORT = 3'd5
    } state_t;

    typedef logic [1:0] stage_t;

    typedef struct packed {
        stage_t     stage;
        logic [2:0] accel;
        logic [3:0] t;
    } dp_step_t;

    localparam int         DEF_BURN1_TICKS = 8;
    localparam int         DEF_BURN2_TICKS = 6;
    localparam int         DEF_BURN3_TICKS = 4;
    localparam logic [2:0] DEF_ACC1        = 3'd3;
    localparam logic [2:0] DEF_ACC2        = 3'd2;
    localparam logic [2:0] DEF_ACC3        = 3'd1;
    localparam int         DEF_ARM_HOLD    = 2;

endpackage

// File: rtl/stage_cfg_lut.sv
// Per-stage configuration lookup: stage index -> acceleration and burn length.
module stage_cfg_lut
    import stage_pkg::*;
#(
    parameter int         BURN1_TICKS = DEF_BURN1_TICKS,
    parameter int         BURN2_TICKS = DEF_BURN2_TICKS,
    parameter int         BURN3_TICKS = DEF_BURN3_TICKS,
    parameter logic [2:0] ACC1        = DEF_ACC1,
    parameter logic [2:0] ACC2        = DEF_ACC2,
    parameter logic [2:0] ACC3        = DEF_ACC3
) (
    input  stage_t     stage,
    output logic [2:0] accel,
    output logic [3:0] ticks
);

    always_comb begin
        accel = '0;
        ticks = '0;
        case (stage)
            2'd1: begin accel = ACC1; ticks = 4'(BURN1_TICKS); end
            2'd2: begin accel = ACC2; ticks = 4'(BURN2_TICKS); end
            2'd3: begin accel = ACC3; ticks = 4'(BURN3_TICKS); end
            default: ;
        endcase
    end

endmodule

// File: rtl/stage_sequencer.sv
// Arm / three-stage burn / separation sequencer issuing step requests to the
// kinematics datapath; abort and ignition loss are terminal until reset.
module stage_sequencer
    import stage_pkg::*;
#(
    parameter int         BURN1_TICKS = DEF_BURN1_TICKS,
    parameter int         BURN2_TICKS = DEF_BURN2_TICKS,
    parameter int         BURN3_TICKS = DEF_BURN3_TICKS,
    parameter logic [2:0] ACC1        = DEF_ACC1,
    parameter logic [2:0] ACC2        = DEF_ACC2,
    parameter logic [2:0] ACC3        = DEF_ACC3,
    parameter int         ARM_HOLD    = DEF_ARM_HOLD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ignition,
    input  logic       cut,
    input  logic       abort,
    input  logic       dp_ready,
    output logic       dp_valid,
    output logic [1:0] dp_stage,
    output logic [2:0] dp_accel,
    output logic [3:0] dp_t,
    output logic [1:0] stage,
    output logic       burning,
    output logic       mission_done,
    output logic       aborted
);

    state_t     state_q, state_d;
    logic [2:0] arm_q, arm_d, arm_inc;
    logic [3:0] tick_q, tick_d, tick_inc;
    stage_t     stage_q, stage_d;
    logic [2:0] cur_accel;
    logic [3:0] cur_ticks;
    logic       accept;
    dp_step_t   step;

    stage_cfg_lut #(
        .BURN1_TICKS(BURN1_TICKS), .BURN2_TICKS(BURN2_TICKS), .BURN3_TICKS(BURN3_TICKS),
        .ACC1(ACC1), .ACC2(ACC2), .ACC3(ACC3)
    ) u_lut (
        .stage (stage_q),
        .accel (cur_accel),
        .ticks (cur_ticks)
    );

    assign arm_inc  = arm_q + 3'd1;
    assign tick_inc = tick_q + 4'd1;
    assign accept   = (state_q == BURN) && dp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            arm_q   <= '0;
            tick_q  <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            arm_q   <= arm_d;
            tick_q  <= tick_d;
            stage_q <= stage_d;
        end
    end

    always_comb begin
        state_d = state_q;
        arm_d   = arm_q;
        tick_d  = tick_q;
        stage_d = stage_q;
        case (state_q)
            IDLE: begin
                if (abort)
                    state_d = ABORT;
                else if (ignition) begin
                    arm_d = arm_inc;
                    if (arm_inc == 3'(ARM_HOLD))
                        state_d = ARMED;
                end else
                    arm_d = '0;
            end
            ARMED: begin
                if (abort || !ignition)
                    state_d = ABORT;
                else begin
                    state_d = BURN;
                    stage_d = 2'd1;
                    tick_d  = '0;
                end
            end
            BURN: begin
                if (abort || !ignition)
                    state_d = ABORT;
                else begin
                    // An acceptance coinciding with a cut still counts.
                    if (accept)
                        tick_d = tick_inc;
                    if (cut || (accept && tick_inc == cur_ticks))
                        state_d = SEP;
                end
            end
            SEP: begin
                if (abort)
                    state_d = ABORT;
                else if (stage_q == 2'd3)
                    state_d = DONE;
                else begin
                    state_d = BURN;
                    stage_d = stage_q + 2'd1;
                    tick_d  = '0;
                end
            end
            default: ;
        endcase
    end

    // Outputs decode state/counters only; dp_ready never reaches dp_valid.
    assign burning      = (state_q == BURN);
    assign mission_done = (state_q == DONE);
    assign aborted      = (state_q == ABORT);
    assign stage        = (state_q == BURN || state_q == SEP) ? stage_q : 2'd0;
    assign step         = burning ? '{stage: stage_q, accel: cur_accel, t: tick_inc} : '0;
    assign dp_valid     = burning;
    assign dp_stage     = step.stage;
    assign dp_accel     = step.accel;
    assign dp_t         = step.t;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench: stimulus pushes expected per-cycle status and accepted
// steps from a mission-level model; a negedge monitor pops and compares.
module tb_stage_sequencer;

    localparam int ARM_HOLD = 2;
    localparam int M_IDLE = 0, M_ARMED = 1, M_BURN = 2, M_SEP = 3, M_DONE = 4, M_ABORT = 5;

    typedef struct packed {
        logic       v;
        logic [1:0] ds;
        logic [2:0] a;
        logic [3:0] t;
        logic [1:0] st;
        logic       b;
        logic       d;
        logic       ab;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ignition = 1'b0, cut = 1'b0, abort = 1'b0, dp_ready = 1'b0;
    logic       dp_valid, burning, mission_done, aborted;
    logic [1:0] dp_stage, stage;
    logic [2:0] dp_accel;
    logic [3:0] dp_t;

    stage_sequencer dut (
        .clk(clk), .rst_n(rst_n), .ignition(ignition), .cut(cut), .abort(abort),
        .dp_ready(dp_ready), .dp_valid(dp_valid), .dp_stage(dp_stage),
        .dp_accel(dp_accel), .dp_t(dp_t), .stage(stage), .burning(burning),
        .mission_done(mission_done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    obs_t       exp_q[$];
    logic [8:0] acc_q[$];
    int         errors = 0, checks = 0;
    int         m_mode = M_IDLE, m_arm = 0, m_stg = 0, m_tk = 0;
    obs_t       act_o, exp_o;
    logic [8:0] exp_s;

    function automatic logic [2:0] acc_of(input int s);
        return (s == 1) ? 3'd3 : (s == 2) ? 3'd2 : (s == 3) ? 3'd1 : 3'd0;
    endfunction

    function automatic int len_of(input int s);
        return (s == 1) ? 8 : (s == 2) ? 6 : 4;
    endfunction

    // Mission rules: arm after a run of ignition cycles, burn each stage for its
    // tick budget (or until cut), separate, then finish; abort/ignition loss end it.
    task automatic model_step(input bit ign, input bit ct, input bit ab, input bit rdy);
        case (m_mode)
            M_IDLE:
                if (ab) m_mode = M_ABORT;
                else if (ign) begin
                    m_arm++;
                    if (m_arm == ARM_HOLD) m_mode = M_ARMED;
                end else m_arm = 0;
            M_ARMED:
                if (ab || !ign) m_mode = M_ABORT;
                else begin m_mode = M_BURN; m_stg = 1; m_tk = 0; end
            M_BURN:
                if (ab || !ign) m_mode = M_ABORT;
                else begin
                    if (rdy) m_tk++;
                    if (ct || (rdy && m_tk == len_of(m_stg))) m_mode = M_SEP;
                end
            M_SEP:
                if (ab) m_mode = M_ABORT;
                else if (m_stg == 3) m_mode = M_DONE;
                else begin m_stg++; m_tk = 0; m_mode = M_BURN; end
            default: ;
        endcase
    endtask

    task automatic cyc(input bit ign, input bit ct, input bit ab, input bit rdy, input bit rn);
        obs_t e;
        @(posedge clk); #1;
        ignition = ign; cut = ct; abort = ab; dp_ready = rdy; rst_n = rn;
        if (!rn) begin m_mode = M_IDLE; m_arm = 0; m_stg = 0; m_tk = 0; end
        e = '0;
        if (m_mode == M_BURN) begin
            e.v = 1'b1; e.ds = m_stg[1:0]; e.a = acc_of(m_stg); e.t = 4'(m_tk + 1); e.b = 1'b1;
        end
        if (m_mode == M_BURN || m_mode == M_SEP) e.st = m_stg[1:0];
        e.d  = (m_mode == M_DONE);
        e.ab = (m_mode == M_ABORT);
        exp_q.push_back(e);
        if (e.v && rdy) acc_q.push_back({e.ds, e.a, e.t});
        if (rn) model_step(ign, ct, ab, rdy);
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_o = exp_q.pop_front();
            act_o = '{v: dp_valid, ds: dp_stage, a: dp_accel, t: dp_t, st: stage,
                      b: burning, d: mission_done, ab: aborted};
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                $display("FAIL status @%0t: actual v=%b ds=%0d a=%0d t=%0d st=%0d b=%b d=%b ab=%b required v=%b ds=%0d a=%0d t=%0d st=%0d b=%b d=%b ab=%b",
                         $time, act_o.v, act_o.ds, act_o.a, act_o.t, act_o.st, act_o.b, act_o.d, act_o.ab,
                         exp_o.v, exp_o.ds, exp_o.a, exp_o.t, exp_o.st, exp_o.b, exp_o.d, exp_o.ab);
            end
            if (dp_valid === 1'b1 && dp_ready === 1'b1) begin
                checks++;
                if (acc_q.size() == 0) begin
                    errors++;
                    $display("FAIL accept @%0t: actual step %h required none", $time, {dp_stage, dp_accel, dp_t});
                end else begin
                    exp_s = acc_q.pop_front();
                    if ({dp_stage, dp_accel, dp_t} !== exp_s) begin
                        errors++;
                        $display("FAIL accept @%0t: actual step %h required %h", $time, {dp_stage, dp_accel, dp_t}, exp_s);
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0] pat;
        int bc;
        pat = 4'b1001;

        // Nominal mission, then idle in DONE.
        do_reset();
        for (int i = 0; i < 40; i++) cyc(1, 0, 0, 1, 1);

        // Backpressure 1,0,0,1 during stage 1.
        do_reset();
        bc = 0;
        for (int i = 0; i < 60; i++) begin
            if (m_mode == M_BURN && m_stg == 1) begin
                cyc(1, 0, 0, pat[bc % 4], 1);
                bc++;
            end else cyc(1, 0, 0, 1, 1);
        end

        // Cut coinciding with acceptance of stage-2 tick 3.
        do_reset();
        for (int i = 0; i < 40; i++)
            cyc(1, (m_mode == M_BURN && m_stg == 2 && m_tk == 2), 0, 1, 1);

        // Abort together with the final stage-3 acceptance.
        do_reset();
        for (int i = 0; i < 40; i++)
            cyc(1, 0, (m_mode == M_BURN && m_stg == 3 && m_tk == 3), 1, 1);

        // Ignition glitch while arming, then ignition loss mid-burn.
        do_reset();
        cyc(1, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 1);
        cyc(1, 0, 0, 1, 1);
        cyc(1, 0, 0, 1, 1);
        for (int i = 0; i < 20; i++)
            cyc(!(m_mode == M_BURN && m_stg == 1 && m_tk == 2), 0, 0, 1, 1);

        // Reset asserted at stage 2 tick 4, then a fresh nominal mission.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if (m_mode == M_BURN && m_stg == 2 && m_tk == 3) begin
                cyc(1, 0, 0, 1, 0);
                break;
            end
            cyc(1, 0, 0, 1, 1);
        end
        cyc(1, 0, 0, 1, 0);
        for (int i = 0; i < 40; i++) cyc(1, 0, 0, 1, 1);

        // Randomized missions.
        for (int m = 0; m < 25; m++) begin
            do_reset();
            for (int c = 0; c < 70; c++)
                cyc(($urandom % 16) != 0, ($urandom % 20) == 0, ($urandom % 80) == 0,
                    1'($urandom % 2), ($urandom % 150) != 0);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (acc_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual %0d expected steps never accepted, required 0", acc_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
